// File: rtl/ch_frame_scheduler_pkg.sv
// Shared state encoding and sizing helpers for the channel frame scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package ch_frame_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_XFER  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ch_frame_scheduler_rr_arbiter.sv
// Rotate-priority encoder: first requester at or after last+1, wrapping.
// Purely combinational; the caller registers the result.
module ch_frame_scheduler_rr_arbiter
   import ch_frame_scheduler_pkg::*;
#(
   parameter  int ADC_CHANEL = 4,
   localparam int CH_W       = ch_width(ADC_CHANEL)
) (
   input  logic [ADC_CHANEL-1:0] req,
   input  logic [CH_W-1:0]       last,
   output logic [CH_W-1:0]       gnt_idx,
   output logic                  gnt_vld
);

   logic [CH_W-1:0] idx;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = 0; i < ADC_CHANEL; i++) begin
         idx = CH_W'((32'(last) + 32'(i) + 32'd1) % 32'(ADC_CHANEL));
         if (!gnt_vld && req[idx]) begin
            gnt_idx = idx;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ch_frame_scheduler.sv
// Frame-granular round-robin mover from per-channel FIFOs to the output FIFO,
// with back-pressure, starvation timeout and frame/abort statistics.
module ch_frame_scheduler
   import ch_frame_scheduler_pkg::*;
#(
   parameter  int ADC_CHANEL  = 4,
   parameter  int FRAME_WORDS = 2600,
   parameter  int TIMEOUT_CYC = 4096,
   localparam int CH_W        = ch_width(ADC_CHANEL)
) (
   input  logic                         clk_100m,
   input  logic                         reset,
   input  logic                         soft_path_rst,
   input  logic                         enable,
   input  logic [ADC_CHANEL-1:0]        ch_empty,
   output logic [ADC_CHANEL-1:0]        ch_rden,
   input  logic [WORD_W*ADC_CHANEL-1:0] ch_dout,
   input  logic                         out_afull,
   output logic                         out_wr_en,
   output logic [WORD_W-1:0]            out_din,
   output logic [CH_W-1:0]              cur_ch,
   output logic                         busy,
   output logic [31:0]                  frame_cnt,
   output logic [15:0]                  abort_cnt,
   output logic                         timeout_err
);

   localparam logic [CNT_W-1:0] FW_MAX  = CNT_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0] FW_LAST = CNT_W'(FRAME_WORDS - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(ADC_CHANEL - 1);

   state_t            state;
   state_t            state_nx;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   last_grant;
   logic [CH_W-1:0]   arb_idx;
   logic              arb_vld;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  starve_cnt;
   logic              rd_v;
   logic              aborted;
   logic              rd_go;
   logic              starve_inc;
   logic              frame_hit;
   logic              timeout_hit;
   logic              drain_done;
   logic [WORD_W-1:0] ch_word [ADC_CHANEL];

   for (genvar g = 0; g < ADC_CHANEL; g++) begin : g_slice
      assign ch_word[g] = ch_dout[WORD_W*g +: WORD_W];
   end

   ch_frame_scheduler_rr_arbiter #(
      .ADC_CHANEL (ADC_CHANEL)
   ) u_arb (
      .req     (~ch_empty),
      .last    (last_grant),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   assign busy   = (state != ST_IDLE);
   assign cur_ch = grant;

   // afull outranks a freshly non-empty channel: neither a read nor a starve tick
   always_comb begin
      rd_go       = (state == ST_XFER) && !ch_empty[grant] &&
                    !out_afull && (rd_cnt < FW_MAX);
      starve_inc  = (state == ST_XFER) && ch_empty[grant] &&
                    !out_afull && (rd_cnt < FW_MAX);
      frame_hit   = rd_go && (rd_cnt == FW_LAST);
      timeout_hit = starve_inc && (starve_cnt == TO_LAST);
      drain_done  = !rd_v && !out_wr_en;
      ch_rden     = '0;
      ch_rden[grant] = rd_go;
      state_nx    = state;
      unique case (state)
         ST_IDLE: begin
            if (enable) state_nx = ST_ARB;
         end
         ST_ARB: begin
            if (!enable)      state_nx = ST_IDLE;
            else if (arb_vld) state_nx = ST_XFER;
         end
         ST_XFER: begin
            if (frame_hit || timeout_hit) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_done) state_nx = enable ? ST_ARB : ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_100m or posedge reset) begin
      if (reset)              state <= ST_IDLE;
      else if (soft_path_rst) state <= ST_IDLE;
      else                    state <= state_nx;
   end

   always_ff @(posedge clk_100m or posedge reset) begin
      if (reset) begin
         grant       <= '0;
         last_grant  <= LAST_CH;
         rd_cnt      <= '0;
         starve_cnt  <= '0;
         rd_v        <= 1'b0;
         aborted     <= 1'b0;
         out_wr_en   <= 1'b0;
         out_din     <= '0;
         frame_cnt   <= '0;
         abort_cnt   <= '0;
         timeout_err <= 1'b0;
      end else if (soft_path_rst) begin
         grant       <= '0;
         last_grant  <= LAST_CH;
         rd_cnt      <= '0;
         starve_cnt  <= '0;
         rd_v        <= 1'b0;
         aborted     <= 1'b0;
         out_wr_en   <= 1'b0;
         out_din     <= '0;
         frame_cnt   <= '0;
         abort_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         rd_v      <= |ch_rden;
         out_wr_en <= rd_v;
         if (rd_v) out_din <= ch_word[grant];
         unique case (state)
            ST_ARB: begin
               if (enable && arb_vld) begin
                  grant      <= arb_idx;
                  rd_cnt     <= '0;
                  starve_cnt <= '0;
                  aborted    <= 1'b0;
               end
            end
            ST_XFER: begin
               if (rd_go) begin
                  rd_cnt     <= rd_cnt + 1'b1;
                  starve_cnt <= '0;
               end else if (starve_inc) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
               if (timeout_hit) begin
                  aborted     <= 1'b1;
                  timeout_err <= 1'b1;
                  if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  last_grant <= grant;
                  if (!aborted) frame_cnt <= frame_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ch_frame_scheduler.sv
// Bench for ch_frame_scheduler: directed scenarios plus randomized frame loads
// checked against a queue-based round-robin reference model.
module tb_ch_frame_scheduler;

   localparam int NCH = 4;
   localparam int FW  = 4;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           soft_path_rst;
   logic           enable;
   logic [NCH-1:0] ch_empty;
   logic [NCH-1:0] ch_rden;
   logic [32*NCH-1:0] ch_dout;
   logic           out_afull;
   logic           out_wr_en;
   logic [31:0]    out_din;
   logic [1:0]     cur_ch;
   logic           busy;
   logic [31:0]    frame_cnt;
   logic [15:0]    abort_cnt;
   logic           timeout_err;

   logic afull_force;
   logic rand_en;
   logic rnd_bit = 1'b0;

   always #5 clk = ~clk;

   ch_frame_scheduler #(
      .ADC_CHANEL  (NCH),
      .FRAME_WORDS (FW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_100m      (clk),
      .reset         (reset),
      .soft_path_rst (soft_path_rst),
      .enable        (enable),
      .ch_empty      (ch_empty),
      .ch_rden       (ch_rden),
      .ch_dout       (ch_dout),
      .out_afull     (out_afull),
      .out_wr_en     (out_wr_en),
      .out_din       (out_din),
      .cur_ch        (cur_ch),
      .busy          (busy),
      .frame_cnt     (frame_cnt),
      .abort_cnt     (abort_cnt),
      .timeout_err   (timeout_err)
   );

   // Behavioural channel FIFOs: pushes from stimulus, pops on ch_rden
   logic [31:0] mem [NCH][64];
   int          wr_ptr [NCH];
   int          rd_ptr [NCH];
   logic [31:0] dout [NCH];

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         ch_empty[k] = (wr_ptr[k] == rd_ptr[k]);
         ch_dout[32*k +: 32] = dout[k];
      end
   end

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < NCH; k++) begin
         if (reset || soft_path_rst) begin
            rd_ptr[k] <= wr_ptr[k];
         end else if (ch_rden[k] && rd_ptr[k] != wr_ptr[k]) begin
            dout[k]   <= mem[k][rd_ptr[k] % 64];
            rd_ptr[k] <= rd_ptr[k] + 1;
         end
      end
   end

   always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
   assign out_afull = afull_force | (rand_en & rnd_bit);

   // Output-side monitor
   logic [31:0] got [$];
   int          rden_n [NCH];
   int          rden_afull = 0;

   always @(negedge clk) begin
      if (out_wr_en) got.push_back(out_din);
      for (int k = 0; k < NCH; k++)
         if (ch_rden[k]) rden_n[k] = rden_n[k] + 1;
      if (out_afull && (|ch_rden)) rden_afull = rden_afull + 1;
   end

   int          n_chk = 0;
   int          n_err = 0;
   int          m_last;
   int          nfr [NCH];
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [31:0] w);
      mem[k][wr_ptr[k] % 64] = w;
      wr_ptr[k] = wr_ptr[k] + 1;
   endtask

   function automatic logic [31:0] wd(input logic [15:0] salt, input int ch,
                                      input int fr, input int w);
      return {salt, 4'(ch), 4'(fr), 8'(w)};
   endfunction

   task automatic soft_reset();
      soft_path_rst = 1'b1;
      step(1);
      soft_path_rst = 1'b0;
      step(1);
      m_last = NCH - 1;
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      int t = 0;
      while (frame_cnt != 32'(n) && t < budget) begin
         step(1);
         t++;
      end
      chk(tag, frame_cnt, 32'(n));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int t = 0;
      while (busy && t < budget) begin
         step(1);
         t++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_rden(input string tag, input int k, input int n);
      int seen = 0;
      int t = 0;
      while (seen < n && t < 60) begin
         step(1);
         t++;
         if (ch_rden[k]) seen++;
      end
      chk(tag, 32'(seen), 32'(n));
   endtask

   task automatic chk_words(input string tag, input int base);
      logic [31:0] gw;
      chk({tag, "_count"}, 32'(got.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         gw = (base + i < got.size()) ? got[base + i] : 32'hDEADBEEF;
         chk(tag, gw, exp_q[i]);
      end
   endtask

   // Reference: whole frames handed out in strict rotation over channels with work
   task automatic model_run(input logic [15:0] salt);
      int left [NCH];
      int fidx [NCH];
      int pending;
      int c;
      exp_q.delete();
      pending = 0;
      for (int k = 0; k < NCH; k++) begin
         left[k] = nfr[k];
         fidx[k] = 0;
         pending += nfr[k];
      end
      while (pending > 0) begin
         c = -1;
         for (int s = 1; s <= NCH; s++)
            if (c < 0 && left[(m_last + s) % NCH] > 0) c = (m_last + s) % NCH;
         for (int w = 0; w < FW; w++) exp_q.push_back(wd(salt, c, fidx[c], w));
         fidx[c]++;
         left[c]--;
         pending--;
         m_last = c;
      end
   endtask

   task automatic preload(input logic [15:0] salt);
      for (int k = 0; k < NCH; k++)
         for (int f = 0; f < nfr[k]; f++)
            for (int w = 0; w < FW; w++) push(k, wd(salt, k, f, w));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      int          base2;
      int          r1;
      int          ra;
      int          wb;
      int          total;
      logic [15:0] salt;

      reset = 1'b1;
      soft_path_rst = 1'b0;
      enable = 1'b0;
      afull_force = 1'b0;
      rand_en = 1'b0;
      m_last = NCH - 1;
      step(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rden", 32'(ch_rden), 32'd0);
      chk("rst_wr_en", 32'(out_wr_en), 32'd0);
      chk("rst_frame_cnt", frame_cnt, 32'd0);
      chk("rst_abort_cnt", 32'(abort_cnt), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      chk("rst_cur_ch", 32'(cur_ch), 32'd0);
      reset = 1'b0;
      step(1);

      // 1: single frame on ch1
      base = got.size();
      r1 = rden_n[1];
      exp_q.delete();
      for (int w = 0; w < FW; w++) begin
         push(1, 32'hA0 + 32'(w));
         exp_q.push_back(32'hA0 + 32'(w));
      end
      enable = 1'b1;
      wait_frames("s1_frames", 1, 60);
      step(1);
      chk_words("s1_word", base);
      chk("s1_cur_ch", 32'(cur_ch), 32'd1);
      chk("s1_rden_cycles", 32'(rden_n[1] - r1), 32'(FW));
      enable = 1'b0;
      wait_idle("s1_idle", 20);

      // 2: round-robin, two frames per channel
      soft_reset();
      salt = 16'($urandom);
      for (int k = 0; k < NCH; k++) nfr[k] = 2;
      preload(salt);
      model_run(salt);
      base = got.size();
      enable = 1'b1;
      wait_frames("s2_frames", 2 * NCH, 400);
      step(1);
      chk_words("s2_word", base);
      enable = 1'b0;
      wait_idle("s2_idle", 20);

      // 3: back-pressure after the second read of a ch0 frame
      soft_reset();
      salt = 16'($urandom);
      exp_q.delete();
      for (int w = 0; w < FW; w++) begin
         push(0, wd(salt, 0, 0, w));
         exp_q.push_back(wd(salt, 0, 0, w));
      end
      base = got.size();
      ra = rden_afull;
      enable = 1'b1;
      wait_rden("s3_two_reads", 0, 2);
      @(posedge clk);
      #1 afull_force = 1'b1;
      wb = got.size();
      repeat (10) @(posedge clk);
      #1;
      chk("s3_writes_after_afull", 32'(got.size() - wb <= 2), 32'd1);
      afull_force = 1'b0;
      wait_frames("s3_frames", 1, 60);
      step(1);
      chk("s3_rden_during_afull", 32'(rden_afull - ra), 32'd0);
      chk_words("s3_word", base);
      enable = 1'b0;
      wait_idle("s3_idle", 20);

      // 4: ch2 starves after two words, ch3 waits behind it
      soft_reset();
      salt = 16'($urandom);
      exp_q.delete();
      for (int w = 0; w < 2; w++) begin
         push(2, wd(salt, 2, 0, w));
         exp_q.push_back(wd(salt, 2, 0, w));
      end
      for (int w = 0; w < FW; w++) push(3, wd(salt, 3, 0, w));
      base = got.size();
      enable = 1'b1;
      wait_rden("s4_two_reads", 2, 2);
      step(TO);
      chk("s4_abort_early", 32'(abort_cnt), 32'd0);
      chk("s4_timeout_early", 32'(timeout_err), 32'd0);
      step(1);
      chk("s4_abort_cnt", 32'(abort_cnt), 32'd1);
      chk("s4_timeout_err", 32'(timeout_err), 32'd1);
      chk("s4_frame_cnt", frame_cnt, 32'd0);
      chk_words("s4_partial", base);
      base2 = got.size();
      exp_q.delete();
      for (int w = 0; w < FW; w++) exp_q.push_back(wd(salt, 3, 0, w));
      wait_frames("s4_next_frame", 1, 60);
      step(1);
      chk("s4_next_grant", 32'(cur_ch), 32'd3);
      chk_words("s4_ch3_word", base2);
      chk("s4_abort_kept", 32'(abort_cnt), 32'd1);
      enable = 1'b0;
      wait_idle("s4_idle", 20);

      // 5: enable drops after the first read; frame still completes
      soft_reset();
      salt = 16'($urandom);
      exp_q.delete();
      for (int w = 0; w < FW; w++) begin
         push(0, wd(salt, 0, 0, w));
         exp_q.push_back(wd(salt, 0, 0, w));
      end
      base = got.size();
      enable = 1'b1;
      wait_rden("s5_first_read", 0, 1);
      enable = 1'b0;
      wait_frames("s5_frames", 1, 60);
      wait_idle("s5_idle", 20);
      step(1);
      chk_words("s5_word", base);
      r1 = rden_n[1];
      push(1, 32'h5151_0000);
      step(10);
      chk("s5_no_rden", 32'(rden_n[1] - r1), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);

      // 6: async reset in the middle of a frame
      for (int w = 1; w < FW; w++) push(1, 32'h5151_0000 + 32'(w));
      enable = 1'b1;
      wait_frames("s6_pre_frame", 2, 60);
      for (int w = 0; w < FW; w++) push(0, 32'h6060_0000 + 32'(w));
      wait_rden("s6_two_reads", 0, 2);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("s6_rden", 32'(ch_rden), 32'd0);
      chk("s6_wr_en", 32'(out_wr_en), 32'd0);
      chk("s6_busy", 32'(busy), 32'd0);
      chk("s6_frame_cnt", frame_cnt, 32'd0);
      enable = 1'b0;
      step(2);
      reset = 1'b0;
      m_last = NCH - 1;
      step(1);
      salt = 16'($urandom);
      for (int k = 0; k < NCH; k++) nfr[k] = 0;
      nfr[0] = 1;
      nfr[1] = 1;
      preload(salt);
      model_run(salt);
      base = got.size();
      enable = 1'b1;
      wait_frames("s6_first", 1, 60);
      chk("s6_restart_ch", 32'(cur_ch), 32'd0);
      wait_frames("s6_second", 2, 60);
      step(1);
      chk_words("s6_word", base);
      enable = 1'b0;
      wait_idle("s6_idle", 20);

      // Randomized frame loads with random back-pressure
      for (int it = 0; it < 6; it++) begin
         soft_reset();
         salt = 16'($urandom);
         total = 0;
         for (int k = 0; k < NCH; k++) begin
            nfr[k] = int'($urandom_range(0, 3));
            total += nfr[k];
         end
         preload(salt);
         model_run(salt);
         base = got.size();
         rand_en = 1'b1;
         enable = 1'b1;
         wait_frames("rnd_frames", total, 800);
         enable = 1'b0;
         wait_idle("rnd_idle", 40);
         rand_en = 1'b0;
         step(2);
         chk_words("rnd_word", base);
         chk("rnd_abort_cnt", 32'(abort_cnt), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
